// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage sitting behind the reorder buffer.
// Pops the ROB head once it has finished (stores also wait for the store
// buffer), then presents the architectural side effects one cycle later:
// RAT write, free-list release, store commit and, for a mispredicted branch,
// a one-cycle redirect together with a FLUSH_CYCLES-long flush.
module commit_unit #(
    parameter int ROB_WIDTH      = 4,
    parameter int PHY_WIDTH      = 6,
    parameter int STORE_ID_WIDTH = 4,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      head_valid,
    input  logic                      head_finished,
    input  logic [ROB_WIDTH-1:0]      head_rob_id,
    input  logic [4:0]                head_rd_arch,
    input  logic [PHY_WIDTH-1:0]      head_rd_phy_old,
    input  logic [PHY_WIDTH-1:0]      head_rd_phy_new,
    input  logic                      head_is_store,
    input  logic [STORE_ID_WIDTH-1:0] head_store_id,
    input  logic                      head_mispredict,
    input  logic [31:0]               head_actual_target,
    input  logic                      store_commit_ready,
    output logic                      commit_pop,
    output logic                      commit_valid,
    output logic [ROB_WIDTH-1:0]      commit_rob_id,
    output logic                      arat_we,
    output logic [4:0]                arat_rd_arch,
    output logic [PHY_WIDTH-1:0]      arat_rd_phy,
    output logic                      free_valid,
    output logic [PHY_WIDTH-1:0]      free_phy,
    output logic                      store_commit_valid,
    output logic [STORE_ID_WIDTH-1:0] store_commit_id,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [31:0]               redirect_pc,
    output logic [63:0]               instret
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Counter is 4 bits wide: FLUSH_CYCLES is limited to 1..15.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flush_cnt_q;
    logic [3:0] flush_cnt_d;

    // Head entry is retirable: finished, and a store needs the buffer ready.
    logic       head_retirable;
    logic       head_has_rd;

    // Stage p1: side effects of the instruction popped in the previous cycle.
    logic                      vld_p1;
    logic [ROB_WIDTH-1:0]      rob_id_p1;
    logic                      arat_we_p1;
    logic [4:0]                arat_rd_arch_p1;
    logic [PHY_WIDTH-1:0]      arat_rd_phy_p1;
    logic                      free_vld_p1;
    logic [PHY_WIDTH-1:0]      free_phy_p1;
    logic                      store_vld_p1;
    logic [STORE_ID_WIDTH-1:0] store_id_p1;
    logic                      redirect_vld_p1;
    logic [31:0]               redirect_pc_p1;
    logic [63:0]               instret_p1;

    // Zero a physical-register field unless its enable is set, so idle
    // cycles present all-zero side-effect buses.
    function automatic logic [PHY_WIDTH-1:0] gate_phy(input logic en,
                                                      input logic [PHY_WIDTH-1:0] val);
        return en ? val : '0;
    endfunction

    function automatic logic [4:0] gate_arch(input logic en, input logic [4:0] val);
        return en ? val : 5'd0;
    endfunction

    assign head_retirable = head_valid & head_finished &
                            (~head_is_store | store_commit_ready);
    assign head_has_rd    = (head_rd_arch != 5'd0);

    // State register: FSM state and remaining flush cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic: enter FLUSH on a mispredict pop, leave after the last
    // flush cycle has been presented.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (commit_pop && head_mispredict) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 4'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    // Output logic: pop only in RUN and out of reset; flush mirrors the state.
    always_comb begin
        commit_pop = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            ST_RUN:   commit_pop = rst_n & head_retirable;
            ST_FLUSH: flush      = 1'b1;
            default: begin
                commit_pop = 1'b0;
                flush      = 1'b0;
            end
        endcase
    end

    // Side-effect register: capture the popped entry, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1          <= 1'b0;
            rob_id_p1       <= '0;
            arat_we_p1      <= 1'b0;
            arat_rd_arch_p1 <= 5'd0;
            arat_rd_phy_p1  <= '0;
            free_vld_p1     <= 1'b0;
            free_phy_p1     <= '0;
            store_vld_p1    <= 1'b0;
            store_id_p1     <= '0;
            redirect_vld_p1 <= 1'b0;
            redirect_pc_p1  <= 32'd0;
            instret_p1      <= 64'd0;
        end else begin
            vld_p1          <= commit_pop;
            rob_id_p1       <= commit_pop ? head_rob_id : '0;
            arat_we_p1      <= commit_pop & head_has_rd;
            arat_rd_arch_p1 <= gate_arch(commit_pop & head_has_rd, head_rd_arch);
            arat_rd_phy_p1  <= gate_phy(commit_pop & head_has_rd, head_rd_phy_new);
            free_vld_p1     <= commit_pop & head_has_rd;
            free_phy_p1     <= gate_phy(commit_pop & head_has_rd, head_rd_phy_old);
            store_vld_p1    <= commit_pop & head_is_store;
            store_id_p1     <= (commit_pop & head_is_store) ? head_store_id : '0;
            redirect_vld_p1 <= commit_pop & head_mispredict;
            redirect_pc_p1  <= (commit_pop & head_mispredict) ? head_actual_target : 32'd0;
            instret_p1      <= instret_p1 + 64'(commit_pop);
        end
    end

    assign commit_valid       = vld_p1;
    assign commit_rob_id      = rob_id_p1;
    assign arat_we            = arat_we_p1;
    assign arat_rd_arch       = arat_rd_arch_p1;
    assign arat_rd_phy        = arat_rd_phy_p1;
    assign free_valid         = free_vld_p1;
    assign free_phy           = free_phy_p1;
    assign store_commit_valid = store_vld_p1;
    assign store_commit_id    = store_id_p1;
    assign redirect_valid     = redirect_vld_p1;
    assign redirect_pc        = redirect_pc_p1;
    assign instret            = instret_p1;

endmodule
